sda_kernel_ctrl_multi: RTL
==========================

Name: sda_kernel_ctrl_multi

Overview:
- Next-generation SDAccel kernel control register block; replaces the single-action control register.
- Fans one host ap_ctrl_hs programming interface out to NUM_ACTIONS independent action cores, each using four-phase go/done handshakes.
- Adds a channel-enable mask, auto-restart, an Xilinx-style interrupt register set and a run-cycle counter.
- Sits between the AXI slave register selector (reg_* request port) and the generated action cores.

Parameters:
NUM_ACTIONS, 4, number of action channels (1..8)
REG_ADDR_WIDTH, 6, byte address width of the register port (map occupies 0x00-0x2B)
CYCLE_CNT_WIDTH, 32, run-cycle counter width (<=32, zero-extended on read)

Ports:
clk  in  1  kernel clock
reset  in  1  asynchronous, active-high reset
reg_req  in  1  single-cycle register access strobe
reg_ack  out  1  access complete, exactly 1 cycle after reg_req
reg_write_en  in  1  1=write, 0=read; sampled with reg_req
reg_addr  in  REG_ADDR_WIDTH  byte address; bits [1:0] ignored
reg_wdata  in  32  write data
reg_wstrb  in  4  byte write strobes
reg_rdata  out  32  read data, valid with reg_ack, else 0
go_r  out  NUM_ACTIONS  per-channel go request
go_a  in  NUM_ACTIONS  per-channel go acknowledge
done_r  in  NUM_ACTIONS  per-channel done request
done_a  out  NUM_ACTIONS  per-channel done acknowledge
interrupt  out  1  registered level interrupt
param_buf_base  out  64  parameter buffer pointer
print_buf_base  out  64  print buffer pointer

Behaviour:
- Reset: all registers, outputs, counters and FSMs return to 0/IDLE. ap_idle reads 1 and chan_en reads all-ones. Reset mid-run drops go_r and done_a immediately, with no handshake completion.
- Register map (word offsets); unmapped reads return 0 and unmapped writes are ignored; wstrb applies to all RW registers:
  - 0x00 CTRL: [0] ap_start RW, [1] ap_done RO/clear-on-read, [2] ap_idle RO, [3] ap_ready RO, [7] auto_restart RW.
  - 0x04 GIE[0]; 0x08 IER[0]; 0x0C ISR[0]: write-1 toggles.
  - 0x10/0x14 param_buf_base lo/hi; 0x18/0x1C print_buf_base lo/hi.
  - 0x20 chan_en[NUM_ACTIONS-1:0]: writes are ignored while busy.
  - 0x24 chan_done[NUM_ACTIONS-1:0] RO.
  - 0x28 cycle_cnt RO.
- Register port: reg_ack is registered and pulses 1 cycle after reg_req. A read returns values as of the reg_req cycle.
- Launch: a write with ap_start=1 while idle sets ap_start, which arms a launch on the next cycle.
  - Launch clears chan_done and cycle_cnt, sets busy, and starts every enabled channel FSM.
  - Launch pulses ap_ready for 1 cycle and clears ap_start.
  - A write with ap_start=1 while busy is ignored. Writing ap_start=0 never aborts a run.
- Channel FSM, one per channel (sub-module):
  - IDLE -> GO_REQ (go_r=1).
  - GO_REQ: on go_a=1 -> GO_REL (go_r=0).
  - GO_REL: on go_a=0 -> RUN.
  - RUN: on done_r=1 -> DONE_ACK (done_a=1).
  - DONE_ACK: on done_r=0 -> IDLE (done_a=0), pulsing chan_done_set.
  - Each transition costs 1 cycle after its input is seen. Disabled channels stay IDLE.
- Completion: when chan_done equals chan_en, in the cycle after the last chan_done_set:
  - busy clears; ap_done and ISR[0] are set; cycle_cnt freezes.
  - With chan_en=0, completion occurs 1 cycle after launch.
- cycle_cnt: increments every busy cycle and saturates at all-ones.
- auto_restart=1: completion sets ap_start in the same cycle, so the next launch follows 1 cycle later. ap_done is still set.
- Simultaneous events: when set and clear coincide, set wins. This covers ap_done set vs read-clear, and ISR set vs toggle write.
- interrupt is registered: interrupt = GIE & IER[0] & ISR[0], updating 1 cycle after any input change.

Decomposition:
- Package sda_kernel_ctrl_pkg holds:
  - register offset constants and CTRL bit index constants;
  - the channel FSM state enum;
  - the default chan_en value.
- Sub-module sda_action_chan_ctrl is instantiated NUM_ACTIONS times in a generate loop. Its ports are clk, reset, start, go_r, go_a, done_r, done_a, done_set.

Test Plan:
- Reset, then read 0x00 -> 0x00000004. Read 0x20 -> 0x0000000F. go_r=0, interrupt=0.
- Write GIE=1, IER=1, CTRL=1; all 4 actions ack and finish at staggered delays.
  - go_r must fall only after go_a.
  - interrupt rises 1 cycle after ISR sets.
  - Reading 0x00 returns ap_done=1; the second read returns 0x04.
  - Write 0x0C=1 clears interrupt.
- chan_en=0x5, start -> only go_r[0] and go_r[2] assert. Completion needs only those two. 0x24 reads 0x5.
- chan_en=0, start -> ap_done is set 2 cycles after the write's reg_ack. cycle_cnt reads 1.
- auto_restart=1, start -> a second launch occurs without host write: go_r reasserts and cycle_cnt restarts. CTRL=0 write, then completion -> idle.
- Assert reset while channel 1 is in DONE_ACK -> done_a=0 and go_r=0 immediately. The registers read their reset values.

Source files
------------

// File: rtl/sda_kernel_ctrl_pkg.sv
// Shared definitions for the multi-action kernel control block:
// register offsets, CTRL bit positions, channel FSM states, helpers.
package sda_kernel_ctrl_pkg;

   localparam int unsigned OFF_CTRL      = 32'h00;
   localparam int unsigned OFF_GIE       = 32'h04;
   localparam int unsigned OFF_IER       = 32'h08;
   localparam int unsigned OFF_ISR       = 32'h0C;
   localparam int unsigned OFF_PARAM_LO  = 32'h10;
   localparam int unsigned OFF_PARAM_HI  = 32'h14;
   localparam int unsigned OFF_PRINT_LO  = 32'h18;
   localparam int unsigned OFF_PRINT_HI  = 32'h1C;
   localparam int unsigned OFF_CHAN_EN   = 32'h20;
   localparam int unsigned OFF_CHAN_DONE = 32'h24;
   localparam int unsigned OFF_CYCLE_CNT = 32'h28;

   localparam int CTRL_AP_START     = 0;
   localparam int CTRL_AP_DONE      = 1;
   localparam int CTRL_AP_IDLE      = 2;
   localparam int CTRL_AP_READY     = 3;
   localparam int CTRL_AUTO_RESTART = 7;

   localparam logic [7:0] CHAN_EN_DEFAULT = 8'hFF;

   typedef enum logic [2:0] {
      CH_IDLE,
      CH_GO_REQ,
      CH_GO_REL,
      CH_RUN,
      CH_DONE_ACK
   } chan_state_e;

   function automatic logic [31:0] apply_wstrb(
      input logic [31:0] old_v,
      input logic [31:0] wdata,
      input logic [3:0]  wstrb
   );
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sda_action_chan_ctrl.sv
// One action channel: four-phase go handshake, run, four-phase done.
// Ports: start (launch pulse), go_r/go_a, done_r/done_a, done_set pulse.
module sda_action_chan_ctrl
   import sda_kernel_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic go_r,
   input  logic go_a,
   input  logic done_r,
   output logic done_a,
   output logic done_set
);

   chan_state_e state_q, state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= CH_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      done_set = 1'b0;
      go_r     = (state_q == CH_GO_REQ);
      done_a   = (state_q == CH_DONE_ACK);
      case (state_q)
         CH_IDLE:     if (start)   state_d = CH_GO_REQ;
         CH_GO_REQ:   if (go_a)    state_d = CH_GO_REL;
         CH_GO_REL:   if (!go_a)   state_d = CH_RUN;
         CH_RUN:      if (done_r)  state_d = CH_DONE_ACK;
         CH_DONE_ACK: if (!done_r) begin
            state_d  = CH_IDLE;
            done_set = 1'b1;
         end
         default:     state_d = CH_IDLE;
      endcase
   end

endmodule

// File: rtl/sda_kernel_ctrl_multi.sv
// Host ap_ctrl_hs register block fanning out to NUM_ACTIONS channels.
// Ports: reg_* request port, go/done handshakes, interrupt, buffer bases.
module sda_kernel_ctrl_multi
   import sda_kernel_ctrl_pkg::*;
#(
   parameter int NUM_ACTIONS     = 4,
   parameter int REG_ADDR_WIDTH  = 6,
   parameter int CYCLE_CNT_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      reg_req,
   output logic                      reg_ack,
   input  logic                      reg_write_en,
   input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
   input  logic [31:0]               reg_wdata,
   input  logic [3:0]                reg_wstrb,
   output logic [31:0]               reg_rdata,
   output logic [NUM_ACTIONS-1:0]    go_r,
   input  logic [NUM_ACTIONS-1:0]    go_a,
   input  logic [NUM_ACTIONS-1:0]    done_r,
   output logic [NUM_ACTIONS-1:0]    done_a,
   output logic                      interrupt,
   output logic [63:0]               param_buf_base,
   output logic [63:0]               print_buf_base
);

   localparam int AW = REG_ADDR_WIDTH;
   localparam int NA = NUM_ACTIONS;
   localparam int CW = CYCLE_CNT_WIDTH;

   localparam logic [AW-1:0] A_CTRL  = AW'(OFF_CTRL);
   localparam logic [AW-1:0] A_GIE   = AW'(OFF_GIE);
   localparam logic [AW-1:0] A_IER   = AW'(OFF_IER);
   localparam logic [AW-1:0] A_ISR   = AW'(OFF_ISR);
   localparam logic [AW-1:0] A_PRMLO = AW'(OFF_PARAM_LO);
   localparam logic [AW-1:0] A_PRMHI = AW'(OFF_PARAM_HI);
   localparam logic [AW-1:0] A_PRTLO = AW'(OFF_PRINT_LO);
   localparam logic [AW-1:0] A_PRTHI = AW'(OFF_PRINT_HI);
   localparam logic [AW-1:0] A_CHEN  = AW'(OFF_CHAN_EN);
   localparam logic [AW-1:0] A_CHDN  = AW'(OFF_CHAN_DONE);
   localparam logic [AW-1:0] A_CCNT  = AW'(OFF_CYCLE_CNT);

   logic          ap_start_q, ap_start_d;
   logic          ap_done_q, ap_done_d;
   logic          auto_rst_q, auto_rst_d;
   logic          busy_q, busy_d;
   logic          gie_q, gie_d;
   logic          ier_q, ier_d;
   logic          isr_q, isr_d;
   logic          irq_q, irq_d;
   logic [63:0]   prm_q, prm_d;
   logic [63:0]   prt_q, prt_d;
   logic [NA-1:0] chan_en_q, chan_en_d;
   logic [NA-1:0] chan_done_q, chan_done_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ack_q;
   logic [31:0]   rdata_q, rd_mux, ctrl_rd;
   logic [NA-1:0] done_set;
   logic [AW-1:0] addr_b;
   logic          wr, rd, launch, complete;
   logic          unused_addr;

   assign addr_b      = {reg_addr[AW-1:2], 2'b00};
   assign unused_addr = ^reg_addr[1:0];
   assign wr          = reg_req & reg_write_en;
   assign rd          = reg_req & ~reg_write_en;
   assign launch      = ap_start_q & ~busy_q;
   assign complete    = busy_q & (chan_done_q == chan_en_q);

   for (genvar i = 0; i < NA; i++) begin : g_chan
      sda_action_chan_ctrl u_chan (
         .clk      (clk),
         .reset    (reset),
         .start    (launch & chan_en_q[i]),
         .go_r     (go_r[i]),
         .go_a     (go_a[i]),
         .done_r   (done_r[i]),
         .done_a   (done_a[i]),
         .done_set (done_set[i])
      );
   end

   always_comb begin
      ctrl_rd = '0;
      ctrl_rd[CTRL_AP_START]     = ap_start_q;
      ctrl_rd[CTRL_AP_DONE]      = ap_done_q;
      ctrl_rd[CTRL_AP_IDLE]      = ~busy_q;
      ctrl_rd[CTRL_AP_READY]     = launch;
      ctrl_rd[CTRL_AUTO_RESTART] = auto_rst_q;
   end

   always_comb begin
      rd_mux = '0;
      case (addr_b)
         A_CTRL:  rd_mux = ctrl_rd;
         A_GIE:   rd_mux = {31'd0, gie_q};
         A_IER:   rd_mux = {31'd0, ier_q};
         A_ISR:   rd_mux = {31'd0, isr_q};
         A_PRMLO: rd_mux = prm_q[31:0];
         A_PRMHI: rd_mux = prm_q[63:32];
         A_PRTLO: rd_mux = prt_q[31:0];
         A_PRTHI: rd_mux = prt_q[63:32];
         A_CHEN:  rd_mux = 32'(chan_en_q);
         A_CHDN:  rd_mux = 32'(chan_done_q);
         A_CCNT:  rd_mux = 32'(cnt_q);
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      ap_start_d  = ap_start_q;
      ap_done_d   = ap_done_q;
      auto_rst_d  = auto_rst_q;
      busy_d      = busy_q;
      gie_d       = gie_q;
      ier_d       = ier_q;
      isr_d       = isr_q;
      prm_d       = prm_q;
      prt_d       = prt_q;
      chan_en_d   = chan_en_q;
      chan_done_d = chan_done_q | done_set;
      cnt_d       = cnt_q;
      irq_d       = gie_q & ier_q & isr_q;

      if (wr && reg_wstrb[0]) begin
         case (addr_b)
            A_CTRL: begin
               auto_rst_d = reg_wdata[CTRL_AUTO_RESTART];
               // pending or running starts absorb a second start
               if (reg_wdata[CTRL_AP_START] && !busy_q && !ap_start_q)
                  ap_start_d = 1'b1;
            end
            A_GIE:  gie_d = reg_wdata[0];
            A_IER:  ier_d = reg_wdata[0];
            A_ISR:  if (reg_wdata[0]) isr_d = ~isr_q;
            A_CHEN: if (!busy_q && !ap_start_q)
               chan_en_d = reg_wdata[NA-1:0];
            default: ;
         endcase
      end

      if (wr) begin
         case (addr_b)
            A_PRMLO: prm_d[31:0]  = apply_wstrb(prm_q[31:0], reg_wdata, reg_wstrb);
            A_PRMHI: prm_d[63:32] = apply_wstrb(prm_q[63:32], reg_wdata, reg_wstrb);
            A_PRTLO: prt_d[31:0]  = apply_wstrb(prt_q[31:0], reg_wdata, reg_wstrb);
            A_PRTHI: prt_d[63:32] = apply_wstrb(prt_q[63:32], reg_wdata, reg_wstrb);
            default: ;
         endcase
      end

      if (rd && addr_b == A_CTRL) ap_done_d = 1'b0;

      if (busy_q && cnt_q != '1) cnt_d = cnt_q + CW'(1);

      if (launch) begin
         ap_start_d  = 1'b0;
         busy_d      = 1'b1;
         chan_done_d = '0;
         cnt_d       = '0;
      end

      // set beats a coincident read-clear or toggle write
      if (complete) begin
         busy_d    = 1'b0;
         ap_done_d = 1'b1;
         isr_d     = 1'b1;
         cnt_d     = cnt_q;
         if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
         if (auto_rst_q) ap_start_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ap_start_q  <= 1'b0;
         ap_done_q   <= 1'b0;
         auto_rst_q  <= 1'b0;
         busy_q      <= 1'b0;
         gie_q       <= 1'b0;
         ier_q       <= 1'b0;
         isr_q       <= 1'b0;
         irq_q       <= 1'b0;
         prm_q       <= '0;
         prt_q       <= '0;
         chan_en_q   <= CHAN_EN_DEFAULT[NA-1:0];
         chan_done_q <= '0;
         cnt_q       <= '0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         ap_start_q  <= ap_start_d;
         ap_done_q   <= ap_done_d;
         auto_rst_q  <= auto_rst_d;
         busy_q      <= busy_d;
         gie_q       <= gie_d;
         ier_q       <= ier_d;
         isr_q       <= isr_d;
         irq_q       <= irq_d;
         prm_q       <= prm_d;
         prt_q       <= prt_d;
         chan_en_q   <= chan_en_d;
         chan_done_q <= chan_done_d;
         cnt_q       <= cnt_d;
         ack_q       <= reg_req;
         rdata_q     <= rd ? rd_mux : '0;
      end
   end

   assign reg_ack        = ack_q;
   assign reg_rdata      = rdata_q;
   assign interrupt      = irq_q;
   assign param_buf_base = prm_q;
   assign print_buf_base = prt_q;

endmodule
